// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared status codes, state encoding and limits for the stopwatch
// Purpose: types and constants shared by stopwatch_controller and its prescaler.
// Ports: none (package).
package sw_pkg;

  localparam logic [1:0] STATUS_RESET = 2'b00;
  localparam logic [1:0] STATUS_STOP  = 2'b01;
  localparam logic [1:0] STATUS_RUN   = 2'b10;

  // State values equal their status codes so status is a direct decode.
  typedef enum logic [1:0] {
    IDLE  = STATUS_RESET,
    PAUSE = STATUS_STOP,
    RUN   = STATUS_RUN
  } sw_state_e;

  localparam int SEC_MAX_DEF = 59;
  localparam int MIN_MAX_DEF = 99;

endpackage

// File: rtl/sec_prescaler.sv
// rtl/sec_prescaler.sv - clk-cycle prescaler producing the one-second terminal count
// Purpose: counts enabled cycles 0..TICKS_PER_SEC-1 and flags the terminal count.
// Ports:
//   clk   in  1  clock
//   rst   in  1  synchronous reset, active-low
//   en    in  1  advance the count this cycle
//   clr   in  1  force the count to 0 (wins over en)
//   hold  in  1  stay at the terminal count instead of wrapping (saturation)
//   tc    out 1  count == TICKS_PER_SEC-1 while en is high
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic hold,
  output logic tc
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] count_q, count_d;

  assign tc = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (count_q == LAST) begin
        count_d = hold ? count_q : '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - mm:ss stopwatch sequencer: buttons, seconds, minute tick
// Purpose: turns start/stop and clear buttons into the counter status, runs the
//          seconds count and emits the minute tick, saturating at MIN_MAX:SEC_MAX.
// Ports:
//   clk         in  1  clock
//   rst         in  1  synchronous reset, active-low
//   start_stop  in  1  start/stop button level
//   clear       in  1  clear button level
//   minutes_in  in  8  minutes value fed back from the minutes counter
//   status      out 2  00 reset, 01 stop, 10 running
//   tick_out    out 1  one-cycle pulse to the minutes counter
//   seconds     out 6  current seconds 0..SEC_MAX
module stopwatch_controller
  import sw_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int SEC_MAX       = SEC_MAX_DEF,
  parameter int MIN_MAX       = MIN_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic [7:0] minutes_in,
  output logic [1:0] status,
  output logic       tick_out,
  output logic [5:0] seconds
);

  localparam logic [5:0] SEC_LAST = 6'(SEC_MAX);
  localparam logic [7:0] MIN_LAST = 8'(MIN_MAX);

  sw_state_e  state_q, state_d;
  logic [5:0] seconds_q, seconds_d;
  logic       tick_q, tick_d;
  logic       start_stop_q, clear_q;

  logic press, clr_evt, sat, pre_en, pre_clr, tc;

  assign press   = start_stop & ~start_stop_q;
  assign clr_evt = clear & ~clear_q;

  // Last second of the last minute: the next TC saturates instead of wrapping.
  assign sat = (seconds_q == SEC_LAST) && (minutes_in >= MIN_LAST);

  // Any button event in RUN suppresses that cycle's TC; clearing the prescaler
  // whenever IDLE keeps it parked at 0 without a separate path.
  assign pre_en  = (state_q == RUN) && !press && !clr_evt;
  assign pre_clr = (state_q == IDLE) || (clr_evt && (state_q != IDLE));

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (pre_en),
    .clr (pre_clr),
    .hold(sat),
    .tc  (tc)
  );

  always_comb begin
    state_d   = state_q;
    seconds_d = seconds_q;
    tick_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        seconds_d = '0;
        if (press) state_d = RUN;
      end
      RUN: begin
        if (clr_evt) begin
          state_d   = IDLE;
          seconds_d = '0;
        end else if (press) begin
          state_d = PAUSE;
        end else if (tc) begin
          if (seconds_q != SEC_LAST) begin
            seconds_d = seconds_q + 1'b1;
          end else if (sat) begin
            state_d = PAUSE;
          end else begin
            seconds_d = '0;
            tick_d    = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (clr_evt) begin
          state_d   = IDLE;
          seconds_d = '0;
        end else if (press) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = IDLE;
        seconds_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      seconds_q    <= '0;
      tick_q       <= 1'b0;
      start_stop_q <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      seconds_q    <= seconds_d;
      tick_q       <= tick_d;
      start_stop_q <= start_stop;
      clear_q      <= clear;
    end
  end

  assign status   = state_q;
  assign tick_out = tick_q;
  assign seconds  = seconds_q;

endmodule
